// File: rtl/window_gen_if.sv
// Pixel-in / window-out handshake bundle between the raster source, window_gen and conv.
interface window_gen_if #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8
);
  logic signed [WIDTH_BIT-1:0]                       pix_in;
  logic                                              pix_valid;
  logic                                              pix_sof;
  logic                                              pix_ready;
  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]   winMatrix;
  logic                                              win_valid;
  logic                                              win_ready;
  logic                                              frame_done;

  // Pixel source / window consumer side.
  modport master (
    output pix_in, pix_valid, pix_sof, win_ready,
    input  pix_ready, winMatrix, win_valid, frame_done
  );

  // Window generator side.
  modport slave (
    input  pix_in, pix_valid, pix_sof, win_ready,
    output pix_ready, winMatrix, win_valid, frame_done
  );
endinterface

// File: rtl/window_gen.sv
// Sliding SIZE x SIZE window generator over a raster pixel stream (valid-mode, no padding).
module window_gen #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic        clock,
  input  logic        reset,
  window_gen_if.slave bus
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0]                           col;
  logic [CW-1:0]                           pos_col;
  logic [RW-1:0]                           row;
  logic [RW-1:0]                           pos_row;
  logic                                    ready_c;
  logic                                    accept;
  logic                                    last_col;
  logic                                    last_row;
  logic                                    win_ok;
  logic [WIDTH_BIT-1:0]                    line [SIZE-1][IMG_W];
  logic [SIZE-1:0][WIDTH_BIT-1:0]          new_col;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_q;
  logic                                    win_valid_q;
  logic                                    frame_done_q;

  assign ready_c        = !win_valid_q || bus.win_ready;
  assign bus.pix_ready  = ready_c;
  assign bus.winMatrix  = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

  // Position of the incoming pixel (sof resyncs to the frame origin) and the column entering the window.
  always_comb begin
    accept   = bus.pix_valid && ready_c;
    pos_col  = bus.pix_sof ? '0 : col;
    pos_row  = bus.pix_sof ? '0 : row;
    last_col = (pos_col == CW'(IMG_W - 1));
    last_row = (pos_row == RW'(IMG_H - 1));
    win_ok   = (pos_row >= RW'(SIZE - 1)) && (pos_col >= CW'(SIZE - 1));
    new_col  = '0;
    new_col[SIZE-1] = bus.pix_in;
    for (int i = 0; i < SIZE - 1; i++) begin
      new_col[i] = line[SIZE-2-i][pos_col];
    end
  end

  // Raster position counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : pos_row + RW'(1);
      end else begin
        col <= pos_col + CW'(1);
        row <= pos_row;
      end
    end
  end

  // Line buffers: push the new pixel into line 0 and age older rows down; contents need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      line[0][pos_col] <= bus.pix_in;
      for (int k = 1; k < SIZE - 1; k++) begin
        line[k][pos_col] <= line[k-1][pos_col];
      end
    end
  end

  // Window shift register, window valid flag and end-of-frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && last_col && last_row;
      if (accept) begin
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE - 1; j++) begin
            win_q[i][j] <= win_q[i][j+1];
          end
          win_q[i][SIZE-1] <= new_col[i];
        end
        win_valid_q <= win_ok;
      end else begin
        win_valid_q <= win_valid_q && !bus.win_ready;
      end
    end
  end
endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen: SIZE=3 over a 5x4 frame.
module tb_window_gen;
  localparam int SIZE  = 3;
  localparam int WB    = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  typedef logic [SIZE-1:0][SIZE-1:0][WB-1:0] win_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  window_gen_if #(.SIZE(SIZE), .WIDTH_BIT(WB)) bus ();

  window_gen #(.SIZE(SIZE), .WIDTH_BIT(WB), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          got_win   = 0;
  int          fd_seen   = 0;
  bit          stall_arm = 1'b0;
  win_t        exp_q[$];
  logic [WB-1:0] frm [NPIX];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected window whose newest pixel is (r,c) of the current frame.
  function automatic win_t win_of(input int r, input int c);
    win_t w;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        w[i][j] = frm[(r - (SIZE-1) + i) * IMG_W + (c - (SIZE-1) + j)];
    return w;
  endfunction

  task automatic send(input logic [WB-1:0] v, input bit sof, input bit last, input bit exp_v);
    int guard = 0;
    bus.pix_in    = v;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    @(negedge clock);
    while (!bus.pix_ready && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    if (!bus.pix_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL pix_ready_timeout: got 0, expected 1 within 200 cycles");
    end
    @(posedge clock);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    check("win_valid_after_accept", 72'(bus.win_valid), 72'(exp_v));
    if (last) check("frame_done_pulse", 72'(bus.frame_done), 72'(1));
  endtask

  task automatic run_frame(input int n, input bit sof);
    for (int k = 0; k < n; k++) begin
      int r;
      int c;
      bit wv;
      r  = k / IMG_W;
      c  = k % IMG_W;
      wv = (r >= SIZE-1) && (c >= SIZE-1);
      if (wv) exp_q.push_back(win_of(r, c));
      send(frm[k], sof && (k == 0), (r == IMG_H-1) && (c == IMG_W-1), wv);
    end
  endtask

  task automatic end_test(input string name, input int wins, input int fds);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clock);
      guard++;
    end
    repeat (3) @(posedge clock);
    #1;
    check({name, "_drain"}, 72'(exp_q.size()), 72'(0));
    check({name, "_windows"}, 72'(got_win), 72'(wins));
    check({name, "_frame_done"}, 72'(fd_seen), 72'(fds));
    exp_q.delete();
    got_win = 0;
    fd_seen = 0;
  endtask

  task automatic ramp();
    for (int k = 0; k < NPIX; k++) frm[k] = WB'(k);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_win_valid"}, 72'(bus.win_valid), 72'(0));
    check({name, "_frame_done"}, 72'(bus.frame_done), 72'(0));
    check({name, "_pix_ready"}, 72'(bus.pix_ready), 72'(1));
    check({name, "_winMatrix"}, 72'(bus.winMatrix), 72'(0));
  endtask

  // Monitor: pop and compare on every consumed window; check hold behaviour while stalled.
  initial begin : monitor
    win_t held;
    bit   stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock);
      if (bus.win_valid && bus.win_ready) begin
        got_win++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: got %h, expected no window", bus.winMatrix);
        end else begin
          check("window", bus.winMatrix, exp_q.pop_front());
        end
        stalled = 1'b0;
      end else if (bus.win_valid) begin
        check("stall_pix_ready", 72'(bus.pix_ready), 72'(0));
        if (stalled) check("stall_hold", bus.winMatrix, held);
        held    = bus.winMatrix;
        stalled = 1'b1;
      end
      if (bus.frame_done) fd_seen++;
    end
  end

  // Drops win_ready for 4 cycles on the first window seen once armed.
  initial begin : stall_ctl
    forever begin
      @(posedge clock);
      #1;
      if (stall_arm && bus.win_valid) begin
        bus.win_ready = 1'b0;
        stall_arm     = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        bus.win_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.win_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // 1: plain ramp frame
    ramp();
    run_frame(NPIX, 1'b1);
    end_test("t1", 6, 1);

    // 2: downstream stall on the first window
    stall_arm = 1'b1;
    run_frame(NPIX, 1'b1);
    end_test("t2", 6, 1);

    // 3: signed extremes at k=12
    ramp();
    frm[12] = 8'h80;
    run_frame(NPIX, 1'b1);
    end_test("t3a", 6, 1);
    frm[12] = 8'h7F;
    run_frame(NPIX, 1'b1);
    end_test("t3b", 6, 1);

    // 4: reset mid-frame, then a fresh frame without sof
    ramp();
    frm[0] = 8'hF0;
    run_frame(10, 1'b1);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_state("midreset");
    ramp();
    run_frame(NPIX, 1'b0);
    end_test("t4", 6, 1);

    // 5: partial frame, then sof resync
    run_frame(8, 1'b1);
    run_frame(NPIX, 1'b1);
    end_test("t5", 6, 1);

    // 6: two frames back to back with distinct content
    ramp();
    run_frame(NPIX, 1'b1);
    for (int k = 0; k < NPIX; k++) frm[k] = WB'(100 + k);
    run_frame(NPIX, 1'b0);
    end_test("t6", 12, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
